md_unit: RTL and testbench

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_pkg.sv | 17 +
 rtl/md_if.sv | 20 ++
 rtl/md_core.sv | 56 +++++
 rtl/md_unit.sv | 98 +++++++++
 tb/tb_md_unit.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// Shared encodings and default latencies for the multiply/divide unit.
package md_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_MULT  = 2'd0;
    localparam op_t OP_MULTU = 2'd1;
    localparam op_t OP_DIV   = 2'd2;
    localparam op_t OP_DIVU  = 2'd3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;

endpackage

// File: rtl/md_if.sv
// Request/result bundle between the pipeline and the multiply/divide unit.
interface md_if;
    import md_pkg::*;

    logic        start;
    op_t         op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, a, b, mthi, mtlo, wdata,
                    input  busy, hi, lo);
    modport slave  (input  start, op, a, b, mthi, mtlo, wdata,
                    output busy, hi, lo);
endinterface

// File: rtl/md_core.sv
// Combinational multiply/divide datapath producing the HI/LO pair for one op.
module md_core
    import md_pkg::*;
(
    input  op_t         op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res
);

    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        mag_a;
    logic [31:0]        mag_b;
    logic [31:0]        quo_u;
    logic [31:0]        rem_u;
    logic               is_signed;
    logic               neg_q;
    logic               neg_r;

    always_comb begin
        is_signed = (op == OP_DIV);
        prod_s    = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u    = {32'd0, a} * {32'd0, b};

        // Signed division runs on magnitudes; 0x8000_0000 / -1 falls out as 0x8000_0000 rem 0.
        mag_a = (is_signed && a[31]) ? (~a + 32'd1) : a;
        mag_b = (is_signed && b[31]) ? (~b + 32'd1) : b;
        quo_u = '0;
        rem_u = '0;
        if (b != '0) begin
            quo_u = mag_a / mag_b;
            rem_u = mag_a % mag_b;
        end
        neg_q = is_signed && (a[31] ^ b[31]);
        neg_r = is_signed && a[31];

        hi_res = '0;
        lo_res = '0;
        case (op)
            OP_MULT:  {hi_res, lo_res} = prod_s;
            OP_MULTU: {hi_res, lo_res} = prod_u;
            default: begin
                if (b == '0) begin
                    lo_res = '1;
                    hi_res = a;
                end else begin
                    lo_res = neg_q ? (~quo_u + 32'd1) : quo_u;
                    hi_res = neg_r ? (~rem_u + 32'd1) : rem_u;
                end
            end
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit: FSM, latency counter, operand latches and HI/LO.
module md_unit
    import md_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  op_t         op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [0:0]  state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    op_t         op_q,    op_d;
    logic [31:0] a_q,     a_d;
    logic [31:0] b_q,     b_d;
    logic [31:0] hi_q,    hi_d;
    logic [31:0] lo_q,    lo_d;
    logic [31:0] hi_res;
    logic [31:0] lo_res;

    md_core u_core (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .hi_res (hi_res),
        .lo_res (lo_res)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    cnt_d   = (op == OP_MULT || op == OP_MULTU) ? 4'(MUL_LAT) : 4'(DIV_LAT);
                end else begin
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end
            default: begin
                if (cnt_q == 4'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    hi_d    = hi_res;
                    lo_d    = lo_res;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MULT;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: directed ops push expected HI/LO; a monitor checks on busy fall.
module tb_md_unit;
    import md_pkg::*;

    logic clk;
    logic reset;
    md_if bus ();

    md_unit #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (bus.start),
        .op    (bus.op),
        .a     (bus.a),
        .b     (bus.b),
        .mthi  (bus.mthi),
        .mtlo  (bus.mtlo),
        .wdata (bus.wdata),
        .busy  (bus.busy),
        .hi    (bus.hi),
        .lo    (bus.lo)
    );

    typedef struct packed {
        int          id;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n_ops  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor: a busy 1->0 transition outside reset marks a committed result.
    initial begin : monitor
        logic busy_prev;
        exp_t e;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_prev = 1'b0;
            end else begin
                if (busy_prev && !bus.busy) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_underflow: got result %h_%h, expected none", bus.hi, bus.lo);
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("result_hi[%0d]", e.id), bus.hi, e.hi);
                        chk($sformatf("result_lo[%0d]", e.id), bus.lo, e.lo);
                    end
                end
                busy_prev = bus.busy;
            end
        end
    end

    task automatic push_exp(input logic [31:0] eh, input logic [31:0] el);
        sb.push_back('{id: n_ops, hi: eh, lo: el});
        n_ops++;
    endtask

    task automatic wait_idle(input int lat);
        int n;
        n = 0;
        while (bus.busy && n < 64) begin
            n++;
            @(negedge clk);
        end
        chk("busy_len", 32'(n), 32'(lat));
    endtask

    task automatic run_op(input op_t o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el, input int lat);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        push_exp(eh, el);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = ~x;
        bus.b     = y ^ 32'h5A5A_0001;
        wait_idle(lat);
    endtask

    initial begin : stim
        int n;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = OP_MULT;
        bus.a     = '0;
        bus.b     = '0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.wdata = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_hi", bus.hi, 32'd0);
        chk("reset_lo", bus.lo, 32'd0);
        reset = 1'b0;

        run_op(OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 5);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5);
        run_op(OP_MULT,  32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 5);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        run_op(OP_DIVU,  32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, 10);
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 10);
        run_op(OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        10);
        run_op(OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 10);
        run_op(OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 10);

        // DIV 20/3 with a MULT start and mthi thrown at it in busy cycle 3.
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.a     = 32'd20;
        bus.b     = 32'd3;
        push_exp(32'd2, 32'd6);
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (bus.busy && n < 64) begin
            n++;
            if (n == 3) begin
                bus.start = 1'b1;
                bus.op    = OP_MULT;
                bus.a     = 32'd9;
                bus.b     = 32'd9;
                bus.mthi  = 1'b1;
                bus.wdata = 32'd5;
            end else begin
                bus.start = 1'b0;
                bus.mthi  = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        chk("collide_busy_len", 32'(n), 32'd10);
        repeat (3) @(negedge clk);
        chk("collide_busy_after", 32'(bus.busy), 32'd0);
        chk("collide_hi_after", bus.hi, 32'd2);
        chk("collide_lo_after", bus.lo, 32'd6);

        bus.mtlo  = 1'b1;
        bus.wdata = 32'h1234_5678;
        @(negedge clk);
        bus.mtlo = 1'b0;
        chk("mtlo_lo", bus.lo, 32'h1234_5678);
        chk("mtlo_hi", bus.hi, 32'd2);

        bus.mthi  = 1'b1;
        bus.wdata = 32'hAAAA_5555;
        @(negedge clk);
        bus.mthi = 1'b0;
        chk("mthi_hi", bus.hi, 32'hAAAA_5555);
        chk("mthi_lo", bus.lo, 32'h1234_5678);

        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        bus.wdata = 32'h0F0F_0F0F;
        @(negedge clk);
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        chk("mboth_hi", bus.hi, 32'h0F0F_0F0F);
        chk("mboth_lo", bus.lo, 32'h0F0F_0F0F);

        // start and mtlo together: the op wins, LO keeps its old value during RUN.
        bus.start = 1'b1;
        bus.op    = OP_MULTU;
        bus.a     = 32'd3;
        bus.b     = 32'd4;
        bus.mtlo  = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
        push_exp(32'd0, 32'd12);
        @(negedge clk);
        bus.start = 1'b0;
        bus.mtlo  = 1'b0;
        chk("startmv_busy", 32'(bus.busy), 32'd1);
        chk("startmv_lo_run", bus.lo, 32'h0F0F_0F0F);
        chk("startmv_hi_run", bus.hi, 32'h0F0F_0F0F);
        wait_idle(5);

        // Abort a MULT with an asynchronous reset in its second busy cycle.
        bus.start = 1'b1;
        bus.op    = OP_MULT;
        bus.a     = 32'd5;
        bus.b     = 32'd6;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_hi", bus.hi, 32'd0);
        chk("abort_lo", bus.lo, 32'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("abort_hold_busy", 32'(bus.busy), 32'd0);
            chk("abort_hold_hi", bus.hi, 32'd0);
            chk("abort_hold_lo", bus.lo, 32'd0);
        end

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        run_op(OP_MULTU, 32'd9, 32'd9, 32'd0, 32'd81, 5);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
